// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing request path: request FSM
// state encodings, counter widths and default timing constants. Also imported
// by the traffic-light controller so both ends agree on the encoding.
package ped_pkg;

    localparam int STATE_SIZE = 2;

    typedef logic [STATE_SIZE-1:0] ped_state_t;

    localparam ped_state_t IDLE    = 2'd0;
    localparam ped_state_t PENDING = 2'd1;
    localparam ped_state_t LOCKOUT = 2'd2;

    localparam int DEFAULT_TIMER_SCALE     = 16000000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 320000;
    localparam int DEFAULT_LOCKOUT_SECONDS = 5;

    localparam int DEBOUNCE_CNT_WIDTH  = 20;
    localparam int LOCKOUT_TIMER_WIDTH = 30;
    localparam int BLINK_CNT_WIDTH     = 24;

    // True when the full lockout length (seconds * cycles per second) is
    // non-zero and its reload value fits the lockout timer.
    function automatic bit lockout_fits(input longint secs, input longint scale);
        longint total;
        total = secs * scale;
        return (total >= 64'sd1) && (total < (64'sd1 <<< LOCKOUT_TIMER_WIDTH));
    endfunction

endpackage

// File: rtl/ped_button_request_if.sv
// Request/acknowledge handshake between the pedestrian button front end and
// the traffic-light controller. The controller side is the master (it issues
// the acknowledge); the button front end is the slave (it raises requests).
interface ped_button_request_if;

    logic ped_req;
    logic ped_ack;

    modport master (
        input  ped_req,
        output ped_ack
    );

    modport slave (
        output ped_req,
        input  ped_ack
    );

endinterface

// File: rtl/ped_debounce.sv
// Button input conditioning: two-flop synchroniser for the asynchronous,
// active-low button, a stable-level debouncer and a one-cycle press strobe
// generated only on the debounced released->pressed transition.
module ped_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic press
);

    localparam logic [DEBOUNCE_CNT_WIDTH-1:0] CNT_LAST =
        DEBOUNCE_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << DEBOUNCE_CNT_WIDTH)) begin : g_bad_debounce
            $error("ped_debounce: DEBOUNCE_CYCLES out of range for the debounce counter");
        end
    endgenerate

    logic                          sync1_reg;
    logic                          sync2_reg;
    logic                          level_reg;
    logic [DEBOUNCE_CNT_WIDTH-1:0] cnt_reg;
    logic                          press_reg;

    // Synchronise, then accept a new level only after it has differed from the
    // debounced level for DEBOUNCE_CYCLES consecutive clocks; a glitch back to
    // the old level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= button_raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
                press_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/ped_button_request.sv
// Pedestrian push-button front end: debounced press -> latched crossing request
// held toward the controller until acknowledged, followed by a lockout period
// in which presses are discarded. Drives the WAIT lamp.
// Optional feature macro: PED_WAIT_BLINK_EN (WAIT lamp blinks at 1 Hz while a
// request is pending instead of being steadily lit).
module ped_button_request
    import ped_pkg::*;
#(
    parameter int TIMER_SCALE     = DEFAULT_TIMER_SCALE,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_SECONDS = DEFAULT_LOCKOUT_SECONDS
) (
    input  logic                  pin3_clk_16mhz,
    input  logic                  rst,
    input  logic                  pin9_button,
    ped_button_request_if.slave   ped_bus,
    output logic                  pin10_wait_led
);

    localparam longint LOCKOUT_TOTAL = longint'(LOCKOUT_SECONDS) * longint'(TIMER_SCALE);
    localparam logic [LOCKOUT_TIMER_WIDTH-1:0] LOCKOUT_LOAD =
        LOCKOUT_TIMER_WIDTH'(LOCKOUT_TOTAL - 1);

    generate
        if (!lockout_fits(longint'(LOCKOUT_SECONDS), longint'(TIMER_SCALE))) begin : g_bad_lockout
            $error("ped_button_request: LOCKOUT_SECONDS*TIMER_SCALE must be 1..2^30-1");
        end
        if (TIMER_SCALE < 2 || (TIMER_SCALE / 2) > (1 << BLINK_CNT_WIDTH)) begin : g_bad_scale
            $error("ped_button_request: TIMER_SCALE/2 must fit the blink counter");
        end
    endgenerate

    logic press;

    ped_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (pin3_clk_16mhz),
        .rst        (rst),
        .button_raw (pin9_button),
        .press      (press)
    );

    ped_state_t                     state_reg;
    ped_state_t                     state_next;
    logic [LOCKOUT_TIMER_WIDTH-1:0] timer_reg;
    logic [LOCKOUT_TIMER_WIDTH-1:0] timer_next;
    logic                           req_reg;

    // Request FSM: acknowledge wins over a coincident press while pending;
    // a press wins over a stray acknowledge while idle (ack is ignored there).
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            IDLE: begin
                if (press) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (ped_bus.ped_ack) begin
                    state_next = LOCKOUT;
                    timer_next = LOCKOUT_LOAD;
                end
            end
            LOCKOUT: begin
                if (timer_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // State, lockout timer and the registered request output.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            req_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            req_reg   <= (state_next == PENDING);
        end
    end

    assign ped_bus.ped_req = req_reg;

`ifdef PED_WAIT_BLINK_EN
    localparam logic [BLINK_CNT_WIDTH-1:0] BLINK_LAST = BLINK_CNT_WIDTH'(TIMER_SCALE / 2 - 1);

    logic [BLINK_CNT_WIDTH-1:0] blink_cnt_reg;
    logic                       led_reg;

    // WAIT lamp blink: lit on the first pending cycle, toggles every half
    // second while pending, dark as soon as the request is dropped.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            led_reg       <= 1'b0;
        end else if (state_next == PENDING) begin
            if (state_reg != PENDING) begin
                blink_cnt_reg <= '0;
                led_reg       <= 1'b1;
            end else if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg <= '0;
                led_reg       <= ~led_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end else begin
            blink_cnt_reg <= '0;
            led_reg       <= 1'b0;
        end
    end

    assign pin10_wait_led = led_reg;
`else
    // Steady WAIT lamp: lit exactly while the request is pending.
    assign pin10_wait_led = req_reg;
`endif

endmodule

// File: tb/tb_ped_button_request.sv
// Self-checking bench for ped_button_request with TIMER_SCALE=10,
// DEBOUNCE_CYCLES=4, LOCKOUT_SECONDS=2. A cycle-level behavioural model
// (sample delay queue, stable-run debounce, time-stamped lockout release)
// runs alongside the DUT. Honours PED_WAIT_BLINK_EN for the lamp model.
module tb_ped_button_request;

    localparam int TS   = 10;
    localparam int DB   = 4;
    localparam int LS   = 2;
    localparam int LOCK = LS * TS;
    localparam int HALF = TS / 2;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic led;

    ped_button_request_if bus ();

    always #5 clk = ~clk;

    ped_button_request #(
        .TIMER_SCALE     (TS),
        .DEBOUNCE_CYCLES (DB),
        .LOCKOUT_SECONDS (LS)
    ) dut (
        .pin3_clk_16mhz (clk),
        .rst            (rst),
        .pin9_button    (btn),
        .ped_bus        (bus),
        .pin10_wait_led (led)
    );

    int tests = 0;
    int fails = 0;

    // behavioural model state
    bit raw_hist[$];
    bit m_deb;
    int m_run;
    bit m_press_q;
    bit m_pend;
    bit m_lock;
    int m_release;
    int m_edge;
    int m_age;
    bit m_req;
    bit m_led;

    // Advance one clock edge and update the model from the inputs sampled there.
    task automatic tick();
        bit synced;
        bit strobe;
        @(posedge clk);
        m_edge++;
        if (rst) begin
            raw_hist  = '{1'b1, 1'b1};
            m_deb     = 1'b1;
            m_run     = 0;
            m_press_q = 1'b0;
            m_pend    = 1'b0;
            m_lock    = 1'b0;
            m_age     = 0;
        end else begin
            synced = raw_hist.pop_front();
            raw_hist.push_back(btn);
            strobe = 1'b0;
            if (synced != m_deb) begin
                m_run++;
                if (m_run == DB) begin
                    m_deb  = synced;
                    strobe = !synced;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_pend) begin
                if (bus.ped_ack) begin
                    m_pend    = 1'b0;
                    m_lock    = 1'b1;
                    m_release = m_edge + LOCK;
                end else begin
                    m_age++;
                end
            end else if (m_lock) begin
                if (m_edge == m_release) m_lock = 1'b0;
            end else if (m_press_q) begin
                m_pend = 1'b1;
                m_age  = 0;
            end
            m_press_q = strobe;
        end
        m_req = m_pend;
`ifdef PED_WAIT_BLINK_EN
        m_led = m_pend && (((m_age / HALF) % 2) == 0);
`else
        m_led = m_pend;
`endif
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 1'b1;
        bus.ped_ack = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.ped_req !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL reset: req=%b led=%b expected req=0 led=0", bus.ped_req, led);
        end
        rst = 1'b0;
        repeat (4) begin
            tick();
            tests++;
            if ({bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL reset_idle: req=%b led=%b expected %b %b", bus.ped_req, led, m_req, m_led);
            end
        end
        $display("[TB] reset: outputs low after reset");
    endtask

    task automatic test_clean_press();
        int lat = 0;
        bit got = 0;
        int hold = 20 + int'($urandom_range(0, 5));
        btn = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (!got) lat++;
            tests++;
            if ({bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL clean_press k=%0d: req=%b led=%b expected %b %b", k, bus.ped_req, led, m_req, m_led);
            end
            if (!got && bus.ped_req === 1'b1) begin
                got = 1;
                tests++;
                if (led !== 1'b1) begin
                    fails++;
                    $display("FAIL clean_press_led: led=%b expected 1 with req", led);
                end
            end
        end
        tests++;
        if (!got || lat != DB + 3) begin
            fails++;
            $display("FAIL press_latency: got=%0d latency=%0d expected %0d", got, lat, DB + 3);
        end
        btn = 1'b1;
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        tests++;
        if (bus.ped_req !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL ack_drop: req=%b led=%b expected 0 0", bus.ped_req, led);
        end
        repeat (LOCK + 8) tick();
        $display("[TB] clean_press: latency %0d, hold %0d", lat, hold);
    endtask

    task automatic test_bounce();
        bit pat[$];
        bit rose = 0;
        pat = {};
        repeat (3) pat.push_back(1'b0);
        pat.push_back(1'b1);
        repeat (3) pat.push_back(1'b0);
        repeat (10) pat.push_back(1'b1);
        foreach (pat[i]) begin
            btn = pat[i];
            tick();
            tests++;
            if (bus.ped_req !== 1'b0 || {bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL bounce i=%0d: req=%b led=%b expected 0 (model %b %b)", i, bus.ped_req, led, m_req, m_led);
            end
        end
        btn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) btn = 1'b1;
            tick();
            if (bus.ped_req === 1'b1) rose = 1;
            tests++;
            if ({bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL bounce_hold k=%0d: req=%b led=%b expected %b %b", k, bus.ped_req, led, m_req, m_led);
            end
        end
        tests++;
        if (rose !== 1'b1) begin
            fails++;
            $display("FAIL bounce_rise: rose=%b expected 1", rose);
        end
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        repeat (LOCK + 8) tick();
        $display("[TB] bounce: glitchy press rejected, 6-cycle press accepted");
    endtask

    task automatic test_held_ack();
        bit rose = 0;
        btn = 1'b0;
        repeat (DB + 3) tick();
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        for (int k = 0; k < LOCK + 15; k++) begin
            tick();
            tests++;
            if (bus.ped_req !== 1'b0 || {bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL held_ack k=%0d: req=%b led=%b expected 0 (model %b %b)", k, bus.ped_req, led, m_req, m_led);
            end
        end
        btn = 1'b1;
        repeat (10) tick();
        btn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.ped_req === 1'b1) rose = 1;
            tests++;
            if ({bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL held_repress k=%0d: req=%b led=%b expected %b %b", k, bus.ped_req, led, m_req, m_led);
            end
        end
        tests++;
        if (rose !== 1'b1) begin
            fails++;
            $display("FAIL held_rerequest: rose=%b expected 1", rose);
        end
        btn = 1'b1;
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        repeat (LOCK + 8) tick();
        $display("[TB] held_ack: no re-request while held through lockout");
    endtask

    task automatic test_lockout_press();
        int lat = 0;
        bit got = 0;
        btn = 1'b0;
        repeat (DB + 3) tick();
        btn = 1'b1;
        repeat (6) tick();
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        repeat (4) tick();
        btn = 1'b0;
        for (int k = 0; k < LOCK; k++) begin
            if (k == 8) btn = 1'b1;
            tick();
            tests++;
            if (bus.ped_req !== 1'b0 || {bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL lockout_press k=%0d: req=%b led=%b expected 0", k, bus.ped_req, led);
            end
        end
        repeat (6) tick();
        btn = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            lat++;
            if (bus.ped_req === 1'b1) got = 1;
        end
        tests++;
        if (!got || lat != DB + 3) begin
            fails++;
            $display("FAIL post_lockout_latency: got=%0d latency=%0d expected %0d", got, lat, DB + 3);
        end
        btn = 1'b1;
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        repeat (LOCK + 8) tick();
        $display("[TB] lockout_press: press in lockout ignored, later press latency %0d", lat);
    endtask

    task automatic test_simultaneous();
        int n;
        // press and ack together while idle: press wins
        btn = 1'b0;
        n = 0;
        while (!m_press_q && n < 20) begin tick(); n++; end
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        tests++;
        if (n >= 20 || bus.ped_req !== 1'b1) begin
            fails++;
            $display("FAIL idle_press_ack: req=%b expected 1 (wait %0d)", bus.ped_req, n);
        end
        btn = 1'b1;
        repeat (DB + 6) tick();
        // press and ack together while pending: ack wins
        btn = 1'b0;
        n = 0;
        while (!m_press_q && n < 20) begin tick(); n++; end
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        tests++;
        if (n >= 20 || bus.ped_req !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL pend_press_ack: req=%b led=%b expected 0 0 (wait %0d)", bus.ped_req, led, n);
        end
        for (int k = 0; k < LOCK + 6; k++) begin
            tick();
            tests++;
            if (bus.ped_req !== 1'b0) begin
                fails++;
                $display("FAIL pend_press_discard k=%0d: req=%b expected 0", k, bus.ped_req);
            end
        end
        btn = 1'b1;
        repeat (DB + 6) tick();
        // reset while pending drops the request
        btn = 1'b0;
        repeat (DB + 3) tick();
        btn = 1'b1;
        rst = 1'b1;
        tick();
        tests++;
        if (bus.ped_req !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL reset_pending: req=%b led=%b expected 0 0", bus.ped_req, led);
        end
        rst = 1'b0;
        repeat (DB + 6) begin
            tick();
            tests++;
            if ({bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                $display("FAIL reset_recover: req=%b led=%b expected %b %b", bus.ped_req, led, m_req, m_led);
            end
        end
        $display("[TB] simultaneous: ack/press priority and reset-while-pending checked");
    endtask

    task automatic test_wait_lamp();
        int n = 0;
        bit exp_led;
        btn = 1'b0;
        while (bus.ped_req !== 1'b1 && n < 20) begin tick(); n++; end
        btn = 1'b1;
        for (int k = 0; k < 4 * HALF + 3; k++) begin
`ifdef PED_WAIT_BLINK_EN
            exp_led = ((k / HALF) % 2) == 0;
`else
            exp_led = 1'b1;
`endif
            tests++;
            if (n >= 20 || led !== exp_led || led !== m_led) begin
                fails++;
                $display("FAIL wait_lamp k=%0d: led=%b expected %b", k, led, exp_led);
            end
            tick();
        end
        bus.ped_ack = 1'b1;
        tick();
        bus.ped_ack = 1'b0;
        repeat (LOCK + 8) tick();
        $display("[TB] wait_lamp: lamp pattern over %0d pending cycles", 4 * HALF + 3);
    endtask

    task automatic test_random();
        int run_left = 0;
        int errs = 0;
        for (int k = 0; k < 3000; k++) begin
            if (run_left == 0) begin
                btn = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 9));
            end
            run_left--;
            bus.ped_ack = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
            tests++;
            if ({bus.ped_req, led} !== {m_req, m_led}) begin
                fails++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random k=%0d: req=%b led=%b expected %b %b", k, bus.ped_req, led, m_req, m_led);
            end
        end
        bus.ped_ack = 1'b0;
        rst = 1'b0;
        btn = 1'b1;
        repeat (LOCK + 8) tick();
        $display("[TB] random: 3000 cycles vs model");
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b1;
        bus.ped_ack = 1'b0;
        raw_hist = '{1'b1, 1'b1};
        m_deb = 1'b1;
        m_run = 0;
        m_press_q = 1'b0;
        m_pend = 1'b0;
        m_lock = 1'b0;
        m_release = 0;
        m_edge = 0;
        m_age = 0;
        m_req = 1'b0;
        m_led = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_held_ack();
        test_lockout_press();
        test_simultaneous();
        test_wait_lamp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
